// File: rtl/i2s_codec_tx_if.sv
// i2s_codec_tx_if: left/right sample-pair valid/ready handshake feeding the I2S transmitter
interface i2s_codec_tx_if #(parameter int DW = 16);
  logic signed [DW-1:0] lft_smpl;
  logic signed [DW-1:0] rht_smpl;
  logic                 smpl_vld;
  logic                 smpl_rdy;
  modport master (output lft_smpl, rht_smpl, smpl_vld, input smpl_rdy);
  modport slave (input lft_smpl, rht_smpl, smpl_vld, output smpl_rdy);
endinterface

// File: rtl/i2s_codec_tx.sv
// i2s_codec_tx: CS4272 transmit path - MCLK/SCLK/LRCLK generation, one-pair buffer, I2S serializer
module i2s_codec_tx #(
  parameter int DW            = 16,
  parameter bit UNDERRUN_HOLD = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  i2s_codec_tx_if.slave s_if,
  output logic          MCLK,
  output logic          SCLK,
  output logic          LRCLK,
  output logic          SDin,
  output logic          underrun
);
  logic [9:0]      r_cnt;
  logic            r_mclk, r_sclk, r_lrclk, r_sdin, r_underrun, r_rdy, r_full;
  logic [2*DW-1:0] r_buf, r_pair;
  logic            w_acc, w_load, w_full_nxt;
  logic [2*DW-1:0] w_in, w_pair_nxt;
  logic [4:0]      w_idx;
  // r_pair stays intact through the next frame's left p=0 slot, so r_pair[0] is the delayed R[0]
  always_comb begin
    w_acc      = s_if.smpl_vld & r_rdy;
    w_load     = r_cnt == 10'h01F;
    w_in       = {s_if.lft_smpl, s_if.rht_smpl};
    w_full_nxt = ~w_load & (r_full | w_acc);
    w_pair_nxt = r_full ? r_buf : w_acc ? w_in : UNDERRUN_HOLD ? r_pair : '0;
    w_idx      = {r_cnt[9], 4'b0} - {1'b0, r_cnt[8:5]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_mclk     <= 1'b0;
      r_sclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdin     <= 1'b0;
      r_underrun <= 1'b0;
      r_rdy      <= 1'b0;
      r_full     <= 1'b0;
      r_buf      <= '0;
      r_pair     <= '0;
    end else begin
      r_cnt      <= r_cnt + 10'd1;
      r_mclk     <= r_cnt[1];
      r_sclk     <= r_cnt[4];
      r_lrclk    <= r_cnt[9];
      r_sdin     <= r_pair[w_idx];
      r_underrun <= w_load & ~r_full & ~w_acc;
      r_full     <= w_full_nxt;
      r_rdy      <= ~w_full_nxt;
      if (w_acc & ~w_load) r_buf <= w_in;
      if (w_load) r_pair <= w_pair_nxt;
    end
  end
  assign MCLK          = r_mclk;
  assign SCLK          = r_sclk;
  assign LRCLK         = r_lrclk;
  assign SDin          = r_sdin;
  assign underrun      = r_underrun;
  assign s_if.smpl_rdy = r_rdy;
endmodule

// File: tb/tb_i2s_codec_tx.sv
// tb_i2s_codec_tx: scoreboard bench for i2s_codec_tx, zero-fill and hold-on-underrun instances side by side
module tb_i2s_codec_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mclk0, sclk0, lrclk0, sdin0, und0;
  logic mclk1, sclk1, lrclk1, sdin1, und1;
  i2s_codec_tx_if bus0 ();
  i2s_codec_tx_if bus1 ();
  assign bus1.lft_smpl = bus0.lft_smpl;
  assign bus1.rht_smpl = bus0.rht_smpl;
  assign bus1.smpl_vld = bus0.smpl_vld;
  i2s_codec_tx #(.DW(16), .UNDERRUN_HOLD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .s_if(bus0),
    .MCLK(mclk0), .SCLK(sclk0), .LRCLK(lrclk0), .SDin(sdin0), .underrun(und0)
  );
  i2s_codec_tx #(.DW(16), .UNDERRUN_HOLD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .s_if(bus1),
    .MCLK(mclk1), .SCLK(sclk1), .LRCLK(lrclk1), .SDin(sdin1), .underrun(und1)
  );
  always #10 clk = ~clk;
  // reference counter: m_cnt tracks the spec's cnt, m_lag is what the registered clocks show
  logic [9:0] m_cnt, m_lag;
  logic       m_rst;
  always @(posedge clk) begin
    m_rst <= rst;
    m_cnt <= rst ? 10'd0 : m_cnt + 10'd1;
    m_lag <= rst ? 10'd0 : m_cnt;
  end
  int          total = 0, bad = 0;
  logic [31:0] q[$];
  int          clk_err = 0, edge_err = 0, und_long = 0, lr_per_err = 0, und_total = 0;
  longint      cyc = 0, lr_last = -1;
  logic [30:0] acc0 = '0, acc1 = '0;
  logic [31:0] last1 = '0;
  logic        had_frame = 1'b0, us0 = 1'b0, us1 = 1'b0;
  logic        p_sclk = 1'b0, p_lr = 1'b0, p_sd = 1'b0, p_sd1 = 1'b0, p_und = 1'b0;
  int          acc_at;
  logic [31:0] stream[8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if ({mclk0, sclk0, lrclk0, mclk1, sclk1, lrclk1} !== {2{m_lag[1], m_lag[4], m_lag[9]}}) clk_err++;
      if (m_rst) begin
        had_frame = 1'b0;
        us0 = 1'b0;
        us1 = 1'b0;
        last1 = '0;
        lr_last = -1;
        q.delete();
      end else begin
        if ((sdin0 !== p_sd || sdin1 !== p_sd1 || lrclk0 !== p_lr) && !(p_sclk && !sclk0)) edge_err++;
        if (und0 && p_und) und_long++;
        if (lrclk0 && !p_lr) begin
          if (lr_last >= 0 && cyc - lr_last != 1024) lr_per_err++;
          lr_last = cyc;
        end
      end
      if (und0) begin
        und_total++;
        us0 = 1'b1;
      end
      if (und1) us1 = 1'b1;
      if (sclk0 && !p_sclk && !m_rst) begin
        if (m_lag[9:5] == 5'd0) begin
          if (had_frame) begin
            check("und_match", {31'b0, us1}, {31'b0, us0});
            if (us0) begin
              check("frame_zero", {acc0, sdin0}, 32'h0);
              check("frame_hold", {acc1, sdin1}, last1);
            end else begin
              check("q_nonempty", {31'b0, q.size() > 0}, 32'd1);
              if (q.size() > 0) begin
                e = q.pop_front();
                check("frame_dut0", {acc0, sdin0}, e);
                check("frame_dut1", {acc1, sdin1}, e);
                last1 = e;
              end
            end
          end
          us0 = 1'b0;
          us1 = 1'b0;
        end
        if (m_lag[9:5] == 5'd1) had_frame = 1'b1;
        acc0 = {acc0[29:0], sdin0};
        acc1 = {acc1[29:0], sdin1};
      end
      p_sclk = sclk0;
      p_lr = lrclk0;
      p_sd = sdin0;
      p_sd1 = sdin1;
      p_und = und0;
    end
  endtask
  // call at a negedge; returns at a negedge after the pair is accepted
  task automatic send(input logic [15:0] l, input logic [15:0] r, input bit keep_vld);
    int n = 0;
    bus0.lft_smpl = l;
    bus0.rht_smpl = r;
    bus0.smpl_vld = 1'b1;
    while (!bus0.smpl_rdy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'b0, n < 3000}, 32'd1);
    if (n < 3000) begin
      acc_at = int'(m_cnt);
      @(posedge clk);
      #1;
      q.push_back({l, r});
      if (!keep_vld) bus0.smpl_vld = 1'b0;
    end else bus0.smpl_vld = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_cnt(input logic [9:0] v);
    int n = 0;
    while (m_cnt != v && n < 2048) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int u;
    fork
      monitor();
    join_none
    stream = '{32'h0001_FFFF, 32'h8000_7FFF, 32'h1234_ABCD, 32'hFFFF_0001,
               32'h5A5A_A5A5, 32'h0000_8000, 32'h7FFF_0000, 32'hC3C3_3C3C};
    bus0.smpl_vld = 1'b0;
    bus0.lft_smpl = '0;
    bus0.rht_smpl = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {20'b0, mclk0, sclk0, lrclk0, sdin0, und0, bus0.smpl_rdy,
                       mclk1, sclk1, lrclk1, sdin1, und1, bus1.smpl_rdy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_rise", {30'b0, bus0.smpl_rdy, bus1.smpl_rdy}, 32'h3);
    send(16'hA55A, 16'h0F0F, 1'b0);
    check("acc_first", acc_at, 32'd1);
    check("rdy_drop", {30'b0, bus0.smpl_rdy, bus1.smpl_rdy}, 32'h0);
    bus0.lft_smpl = 16'hFFFF;
    bus0.rht_smpl = 16'hFFFF;
    bus0.smpl_vld = 1'b1;
    repeat (10) @(negedge clk);
    check("rdy_full", {31'b0, bus0.smpl_rdy}, 32'h0);
    bus0.smpl_vld = 1'b0;
    wait_cnt(10'h100);
    u = und_total;
    repeat (3072) @(negedge clk);
    check("und_3frames", und_total - u, 32'd3);
    u = und_total;
    for (int i = 0; i < 8; i++) begin
      send(stream[i][31:16], stream[i][15:0], 1'b1);
      if (i > 0) check("acc_slot", acc_at, 32'h020);
    end
    bus0.smpl_vld = 1'b0;
    wait_cnt(10'h01F);
    wait_cnt(10'h100);
    check("und_stream", und_total - u, 32'd0);
    wait_cnt(10'h01F);
    bus0.lft_smpl = 16'h8001;
    bus0.rht_smpl = 16'h7FFE;
    bus0.smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(32'h8001_7FFE);
    bus0.smpl_vld = 1'b0;
    @(negedge clk);
    check("und_same_clk", {30'b0, und0, und1}, 32'h0);
    check("rdy_same_clk", {30'b0, bus0.smpl_rdy, bus1.smpl_rdy}, 32'h3);
    send(16'h7FFF, 16'h8000, 1'b0);
    u = und_total;
    wait_cnt(10'h100);
    repeat (3072) @(negedge clk);
    check("und_hold", und_total - u, 32'd2);
    send(16'hDEAD, 16'hBEEF, 1'b0);
    wait_cnt(10'h150);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {20'b0, mclk0, sclk0, lrclk0, sdin0, und0, bus0.smpl_rdy,
                           mclk1, sclk1, lrclk1, sdin1, und1, bus1.smpl_rdy}, 32'h0);
    rst = 1'b0;
    wait_cnt(10'h020);
    check("und_first_load", {30'b0, und0, und1}, 32'h3);
    repeat (1100) @(negedge clk);
    check("q_drained", q.size(), 32'd0);
    check("clk_gen", clk_err, 32'd0);
    check("sdin_lr_edges", edge_err, 32'd0);
    check("und_width", und_long, 32'd0);
    check("lrclk_period", lr_per_err, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
